// File: rtl/risc_pkg.sv
// Types shared by the write-back distribution blocks.
// This package is also used by the N-to-1 read mux.
package risc_pkg;

  localparam int DATA_W = 16;

  typedef logic [DATA_W-1:0] data_t;

endpackage

// File: rtl/demux_1ton_buf_if.sv
// Bus bundle for the 1-to-N distributor: one valid/ready input stream and N valid/ready output streams.
// Handshake: a word moves when valid & ready are both high at a rising edge. A producer
// holds valid and data steady until that edge. ready may depend combinationally on the
// request fields (sel, bcast), so the producer must not make valid depend on ready.
interface demux_1ton_buf_if
  import risc_pkg::*;
#(
  parameter int N      = 2,
  parameter int DROP_W = 8
);
  localparam int SEL_W = $clog2(N);

  logic              in_valid;
  logic              in_ready;
  data_t             in_data;
  logic [SEL_W-1:0]  sel;
  logic              bcast;
  logic [N-1:0]      out_valid;
  logic [N-1:0]      out_ready;
  data_t             out_data [N];
  logic              err_pulse;
  logic [DROP_W-1:0] drop_cnt;

  modport slave (
    input  in_valid, in_data, sel, bcast, out_ready,
    output in_ready, out_valid, out_data, err_pulse, drop_cnt
  );

  modport master (
    output in_valid, in_data, sel, bcast, out_ready,
    input  in_ready, out_valid, out_data, err_pulse, drop_cnt
  );

endinterface

// File: rtl/demux_chan_buf.sv
// One-entry holding register for a single output channel.
// A load takes priority over a drain, which gives a throughput of one word per cycle.
module demux_chan_buf
  import risc_pkg::*;
(
  input  logic  clk,
  input  logic  rst_n,
  input  logic  load,
  input  data_t din,
  input  logic  ready,
  output logic  valid,
  output data_t dout,
  output logic  can_take
);

  assign can_take = !valid | ready;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      valid <= 1'b0;
      dout  <= '0;
    end else if (load) begin
      valid <= 1'b1;
      dout  <= din;
    end else if (valid && ready) begin
      valid <= 1'b0;
    end
  end

endmodule

// File: rtl/demux_1ton_buf.sv
// 1-to-N write-back distributor: routes each accepted word to channel sel, or to every channel on bcast.
// A sel value beyond N-1 is accepted and discarded, then flagged and counted.
module demux_1ton_buf
  import risc_pkg::*;
#(
  parameter int N      = 2,
  parameter int DROP_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  demux_1ton_buf_if.slave  bus
);

  localparam int SEL_W = $clog2(N);

  logic [N-1:0]      can_take;
  logic [N-1:0]      sel_hit;
  logic [N-1:0]      load;
  logic [N-1:0]      valid_w;
  data_t             data_w [N];
  logic              sel_ok;
  logic              tgt_take;
  logic              in_ready;
  logic              accept;
  logic              drop;
  logic              err_q;
  logic [DROP_W-1:0] cnt_q;

  always_comb begin
    sel_hit = '0;
    for (int i = 0; i < N; i++) begin
      sel_hit[i] = (bus.sel == SEL_W'(i));
    end
  end

  assign sel_ok   = |sel_hit;
  assign tgt_take = |(sel_hit & can_take);

  // An out-of-range target is always ready so the bad word cannot wedge the write-back path.
  assign in_ready = rst_n & (bus.bcast ? &can_take : (!sel_ok | tgt_take));
  assign accept   = bus.in_valid & in_ready;
  assign load     = {N{accept}} & (bus.bcast ? {N{1'b1}} : sel_hit);
  assign drop     = accept & !bus.bcast & !sel_ok;

  for (genvar g = 0; g < N; g++) begin : g_chan
    demux_chan_buf u_chan (
      .clk      (clk),
      .rst_n    (rst_n),
      .load     (load[g]),
      .din      (bus.in_data),
      .ready    (bus.out_ready[g]),
      .valid    (valid_w[g]),
      .dout     (data_w[g]),
      .can_take (can_take[g])
    );
    assign bus.out_data[g] = data_w[g];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      err_q <= 1'b0;
      cnt_q <= '0;
    end else begin
      err_q <= drop;
      if (drop && (cnt_q != {DROP_W{1'b1}})) begin
        cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.in_ready  = in_ready;
  assign bus.out_valid = valid_w;
  assign bus.err_pulse = err_q;
  assign bus.drop_cnt  = cnt_q;

endmodule

// File: tb/tb_demux_1ton_buf.sv
// Directed bench for demux_1ton_buf: an N=4 instance for routing, streaming, broadcast and reset,
// and an N=3 instance for out-of-range drops.
module tb_demux_1ton_buf;
  import risc_pkg::*;

  logic clk;
  logic rst_n;
  int   checks;
  int   errors;
  logic [15:0] exp_q[$];
  logic [15:0] exp_w;
  int   exp_cnt;

  demux_1ton_buf_if #(.N(4), .DROP_W(8)) bus4 ();
  demux_1ton_buf_if #(.N(3), .DROP_W(8)) bus3 ();

  demux_1ton_buf #(.N(4), .DROP_W(8)) u_dut4 (.clk(clk), .rst_n(rst_n), .bus(bus4));
  demux_1ton_buf #(.N(3), .DROP_W(8)) u_dut3 (.clk(clk), .rst_n(rst_n), .bus(bus3));

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic drive4(input logic v, input logic [15:0] d, input logic [1:0] s, input logic b);
    bus4.in_valid = v;
    bus4.in_data  = d;
    bus4.sel      = s;
    bus4.bcast    = b;
  endtask

  initial begin
    checks = 0;
    errors = 0;
    rst_n  = 1'b0;
    drive4(1'b1, 16'h0000, 2'd0, 1'b0);
    bus4.out_ready = 4'b0000;
    bus3.in_valid  = 1'b1;
    bus3.in_data   = 16'h0000;
    bus3.sel       = 2'd0;
    bus3.bcast     = 1'b0;
    bus3.out_ready = 3'b000;

    // reset with in_valid held
    repeat (2) step();
    chk("rst_in_ready4", 32'(bus4.in_ready), 32'h0);
    chk("rst_in_ready3", 32'(bus3.in_ready), 32'h0);
    chk("rst_out_valid4", 32'(bus4.out_valid), 32'h0);
    chk("rst_drop_cnt4", 32'(bus4.drop_cnt), 32'h0);
    chk("rst_err4", 32'(bus4.err_pulse), 32'h0);
    chk("rst_out_data4_2", 32'(bus4.out_data[2]), 32'h0);
    rst_n = 1'b1;
    bus4.in_valid = 1'b0;
    bus3.in_valid = 1'b0;
    step();
    chk("rel_in_ready4", 32'(bus4.in_ready), 32'h1);
    chk("rel_in_ready3", 32'(bus3.in_ready), 32'h1);

    // single word to a stalled channel, then an independent channel
    drive4(1'b1, 16'hA5A5, 2'd2, 1'b0);
    #1 chk("w2_in_ready", 32'(bus4.in_ready), 32'h1);
    step();
    drive4(1'b1, 16'h1234, 2'd2, 1'b0);
    #1 chk("w2_stall_ready", 32'(bus4.in_ready), 32'h0);
    chk("w2_out_valid", 32'(bus4.out_valid), 32'h4);
    chk("w2_out_data", 32'(bus4.out_data[2]), 32'hA5A5);
    drive4(1'b1, 16'h5678, 2'd1, 1'b0);
    #1 chk("w1_in_ready", 32'(bus4.in_ready), 32'h1);
    step();
    bus4.in_valid = 1'b0;
    chk("w1_out_valid", 32'(bus4.out_valid), 32'h6);
    chk("w1_out_data1", 32'(bus4.out_data[1]), 32'h5678);
    chk("w1_out_data2", 32'(bus4.out_data[2]), 32'hA5A5);
    bus4.out_ready = 4'b0110;
    step();
    bus4.out_ready = 4'b0000;
    chk("drain_out_valid", 32'(bus4.out_valid), 32'h0);
    chk("drain_data_held", 32'(bus4.out_data[2]), 32'hA5A5);

    // back-to-back stream through channel 3
    bus4.out_ready = 4'b1000;
    for (int k = 1; k <= 8; k++) begin
      drive4(1'b1, 16'(k), 2'd3, 1'b0);
      #1 chk("str_in_ready", 32'(bus4.in_ready), 32'h1);
      exp_q.push_back(16'(k));
      step();
      chk("str_out_valid", 32'(bus4.out_valid), 32'h8);
      if (exp_q.size() > 0) begin
        exp_w = exp_q.pop_front();
        chk("str_out_data", 32'(bus4.out_data[3]), 32'(exp_w));
      end
    end
    bus4.in_valid = 1'b0;
    step();
    chk("str_end_valid", 32'(bus4.out_valid), 32'h0);
    chk("str_q_empty", 32'(exp_q.size()), 32'h0);
    bus4.out_ready = 4'b0000;

    // broadcast blocked by a full channel 0, then released
    drive4(1'b1, 16'h1111, 2'd0, 1'b0);
    step();
    drive4(1'b1, 16'hBEEF, 2'd2, 1'b1);
    #1 chk("bc_blocked_ready", 32'(bus4.in_ready), 32'h0);
    step();
    chk("bc_blocked_valid", 32'(bus4.out_valid), 32'h1);
    chk("bc_blocked_data0", 32'(bus4.out_data[0]), 32'h1111);
    chk("bc_blocked_data1", 32'(bus4.out_data[1]), 32'h5678);
    chk("bc_blocked_data3", 32'(bus4.out_data[3]), 32'h0008);
    bus4.out_ready = 4'b0001;
    #1 chk("bc_ready", 32'(bus4.in_ready), 32'h1);
    step();
    drive4(1'b0, 16'h0000, 2'd0, 1'b0);
    bus4.out_ready = 4'b0000;
    chk("bc_out_valid", 32'(bus4.out_valid), 32'hF);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("bc_out_data%0d", i), 32'(bus4.out_data[i]), 32'hBEEF);
    end

    // reset with every channel full
    rst_n = 1'b0;
    step();
    chk("mrst_out_valid", 32'(bus4.out_valid), 32'h0);
    chk("mrst_in_ready", 32'(bus4.in_ready), 32'h0);
    for (int i = 0; i < 4; i++) begin
      chk($sformatf("mrst_out_data%0d", i), 32'(bus4.out_data[i]), 32'h0);
    end
    rst_n = 1'b1;
    step();

    // out-of-range drops on the N=3 instance
    chk("drop_cnt_init", 32'(bus3.drop_cnt), 32'h0);
    chk("drop_err_init", 32'(bus3.err_pulse), 32'h0);
    bus3.sel      = 2'd3;
    bus3.in_data  = 16'hDEAD;
    bus3.in_valid = 1'b1;
    exp_cnt = 0;
    for (int c = 0; c < 300; c++) begin
      #1 chk("drop_in_ready", 32'(bus3.in_ready), 32'h1);
      step();
      if (exp_cnt < 255) exp_cnt++;
      chk("drop_err", 32'(bus3.err_pulse), 32'h1);
      chk("drop_cnt", 32'(bus3.drop_cnt), 32'(exp_cnt));
      chk("drop_out_valid", 32'(bus3.out_valid), 32'h0);
    end
    bus3.in_valid = 1'b0;
    step();
    chk("drop_err_end", 32'(bus3.err_pulse), 32'h0);
    chk("drop_cnt_sat", 32'(bus3.drop_cnt), 32'd255);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
